// File: rtl/oam_dma_if.sv
// oam_dma_if: CPU register, external bus and OAM port signals of the OAM DMA block
interface oam_dma_if;
  logic       cpu_en;
  logic       reg_write;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       bus_req;
  logic [15:0] bus_addr;
  logic [7:0] bus_rdata;
  logic [7:0] cpu_oam_addr;
  logic [7:0] cpu_oam_wdata;
  logic       cpu_oam_write;
  logic [7:0] cpu_oam_rdata;
  logic [7:0] oam_addr;
  logic [7:0] oam_wdata;
  logic       oam_write;
  logic [7:0] oam_rdata;
  logic       dma_active;
  modport master (
    input  cpu_en, reg_write, reg_wdata, bus_rdata, cpu_oam_addr, cpu_oam_wdata, cpu_oam_write, oam_rdata,
    output reg_rdata, bus_req, bus_addr, cpu_oam_rdata, oam_addr, oam_wdata, oam_write, dma_active
  );
  modport slave (
    output cpu_en, reg_write, reg_wdata, bus_rdata, cpu_oam_addr, cpu_oam_wdata, cpu_oam_write, oam_rdata,
    input  reg_rdata, bus_req, bus_addr, cpu_oam_rdata, oam_addr, oam_wdata, oam_write, dma_active
  );
endinterface

// File: rtl/oam_dma.sv
// oam_dma: FF46 OAM DMA engine and OAM port arbiter.
// Define OAM_DMA_ECHO_MAP_EN to fold source pages E0h-FFh onto C0h-DFh.
module oam_dma #(
  parameter int OAM_SIZE = 160
) (
  input logic       clk,
  input logic       reset,
  oam_dma_if.master bus
);
  typedef enum logic [1:0] {IDLE, START, XFER} state_t;
  localparam logic [7:0] LAST = 8'(OAM_SIZE - 1);
  state_t     state_q, state_d;
  logic [7:0] src_q, src_d, act_q, act_d, n_q, n_d, eff;
  logic       cont_q, cont_d, own_q, own_d, own;
`ifdef OAM_DMA_ECHO_MAP_EN
  assign eff = src_q >= 8'hE0 ? src_q - 8'h20 : src_q;
`else
  assign eff = src_q;
`endif
  // cont marks a START cycle in which a restarted transfer still copies its next byte
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    act_d   = act_q;
    n_d     = n_q;
    cont_d  = cont_q;
    if (bus.cpu_en) begin
      src_d = bus.reg_write ? bus.reg_wdata : src_q;
      if (bus.reg_write) begin
        state_d = START;
        cont_d  = (state_q == XFER || (state_q == START && cont_q)) && n_q != LAST;
        n_d     = cont_d ? n_q + 8'd1 : 8'd0;
      end else if (state_q == START) begin
        state_d = XFER;
        n_d     = 8'd0;
        act_d   = eff;
        cont_d  = 1'b0;
      end else if (state_q == XFER) begin
        state_d = n_q == LAST ? IDLE : XFER;
        n_d     = n_q == LAST ? 8'd0 : n_q + 8'd1;
      end
    end
    own_d = state_d == XFER || (state_d == START && cont_d);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= 8'hFF;
      act_q   <= 8'h00;
      n_q     <= 8'h00;
      cont_q  <= 1'b0;
      own_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      act_q   <= act_d;
      n_q     <= n_d;
      cont_q  <= cont_d;
      own_q   <= own_d;
    end
  end
  // reset releases the OAM port at once so the aborted byte is never written
  assign own               = own_q & ~reset;
  assign bus.reg_rdata     = src_q;
  assign bus.bus_req       = own;
  assign bus.bus_addr      = own ? {act_q, n_q} : 16'h0000;
  assign bus.oam_addr      = own ? n_q : bus.cpu_oam_addr;
  assign bus.oam_wdata     = own ? bus.bus_rdata : bus.cpu_oam_wdata;
  assign bus.oam_write     = own | bus.cpu_oam_write;
  assign bus.cpu_oam_rdata = own ? 8'hFF : bus.oam_rdata;
  assign bus.dma_active    = own;
endmodule
